// File: rtl/trafik_kavsak_ctrl.sv
// Multi-approach intersection controller: round-robin green/blue/all-red phases,
// a latched pedestrian walk phase and a blue night-flash mode.
module trafik_kavsak_ctrl #(
  parameter int NUM_DIR    = 2,
  parameter int GREEN_TIME = 5_000_000,
  parameter int BLUE_TIME  = 2_000_000,
  parameter int CLEAR_TIME = 1_000_000,
  parameter int PED_TIME   = 4_000_000,
  parameter int BLINK_TIME = 1_000_000,
  parameter int CNT_W      = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       night,
  input  logic                       ped_req,
  output logic [3*NUM_DIR-1:0]       led,
  output logic                       ped_walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int DIR_W = $clog2(NUM_DIR);

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] BLUE_LAST  = CNT_W'(BLUE_TIME - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 1);
  localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_TIME - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TIME - 1);
  localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(NUM_DIR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GREEN, S_BLUE, S_CLEAR, S_PED, S_NIGHT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic                 pend_q, pend_d;
  logic                 blink_q, blink_d;
  logic [3*NUM_DIR-1:0] led_q, led_d;
  logic                 walk_q, walk_d;
  logic [DIR_W-1:0]     dir_next;

  assign dir_next = (dir_q == DIR_LAST) ? '0 : dir_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dir_d   = dir_q;
    pend_d  = pend_q;
    blink_d = blink_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dir_d   = '0;
      pend_d  = 1'b0;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (night) begin
            state_d = S_NIGHT;
            blink_d = 1'b1;
          end else begin
            state_d = S_GREEN;
            dir_d   = '0;
          end
        end
        S_GREEN: begin
          if (ped_req) pend_d = 1'b1;
          if (cnt_q == GREEN_LAST) begin
            state_d = S_BLUE;
            cnt_d   = '0;
          end
        end
        S_BLUE: begin
          if (ped_req) pend_d = 1'b1;
          if (cnt_q == BLUE_LAST) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end
        end
        S_CLEAR: begin
          if (ped_req) pend_d = 1'b1;
          if (cnt_q == CLEAR_LAST) begin
            cnt_d = '0;
            // Exit priority: night, then a latched walk request, then the next approach.
            if (night) begin
              state_d = S_NIGHT;
              blink_d = 1'b1;
            end else if (pend_q) begin
              state_d = S_PED;
              pend_d  = 1'b0;
            end else begin
              state_d = S_GREEN;
              dir_d   = dir_next;
            end
          end
        end
        S_PED: begin
          if (cnt_q == PED_LAST) begin
            state_d = S_GREEN;
            cnt_d   = '0;
            dir_d   = dir_next;
          end
        end
        S_NIGHT: begin
          if (ped_req) pend_d = 1'b1;
          if (!night) begin
            // Parking dir on the last approach makes the following green start at approach 0.
            state_d = S_CLEAR;
            cnt_d   = '0;
            dir_d   = DIR_LAST;
          end else if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    led_d = '0;
    for (int g = 0; g < NUM_DIR; g++) begin
      led_d[3*g +: 3] = 3'b100;
      if (state_d == S_NIGHT)
        led_d[3*g +: 3] = blink_d ? 3'b010 : 3'b000;
      else if (state_d == S_GREEN && dir_d == DIR_W'(g))
        led_d[3*g +: 3] = 3'b001;
      else if (state_d == S_BLUE && dir_d == DIR_W'(g))
        led_d[3*g +: 3] = 3'b010;
    end
    walk_d = (state_d == S_PED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      pend_q  <= 1'b0;
      blink_q <= 1'b0;
      led_q   <= {NUM_DIR{3'b100}};
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      walk_q  <= walk_d;
    end
  end

  assign led        = led_q;
  assign ped_walk   = walk_q;
  assign active_dir = dir_q;

endmodule
